// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: sequences one sweep of the phased-array beamformer.
// Each beam is steered, allowed to settle, its power is collected (or
// abandoned on timeout) and written to the beam-power RAM at the beam index.
// After the last beam, RAM port A is handed to the argmax engine. The
// winning index and power are then latched.
module beam_scan_ctrl #(
  parameter int DW          = 8,
  parameter int AW          = 9,
  parameter int NUM_BEAMS   = 256,
  parameter int SETTLE      = 4,
  parameter int PWR_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          continuous,
  output logic [AW-1:0] steer_idx,
  output logic          steer_load,
  input  logic          pwr_valid,
  input  logic [DW-1:0] pwr_data,
  input  logic [AW-1:0] am_addr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren,
  output logic          am_start,
  input  logic          am_valid,
  input  logic [DW-1:0] am_max,
  input  logic [AW-1:0] am_max_index,
  output logic [AW-1:0] best_index,
  output logic [DW-1:0] best_power,
  output logic          result_valid,
  output logic          busy,
  output logic          timeout_err
);

  // One counter serves both the settle delay and the power timeout.
  localparam int CNT_MAX = (SETTLE > PWR_TIMEOUT) ? SETTLE : PWR_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW-1:0] LAST_IDX     = AW'(NUM_BEAMS - 1);
  localparam logic [AW-1:0] IDX_ONE      = AW'(1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(PWR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEER,
    S_SETTLE,
    S_WAIT_PWR,
    S_WRITE,
    S_AM_START,
    S_AM_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pwr_q, pwr_d;
  logic          am_prev_q, am_prev_d;
  logic          tmo_q, tmo_d;
  logic [AW-1:0] best_index_q, best_index_d;
  logic [DW-1:0] best_power_q, best_power_d;

  // Registered copies of the per-state outputs, so every output leaves a flop.
  logic [AW-1:0] steer_idx_q;
  logic          steer_load_q;
  logic          wren_q;
  logic          am_start_q;
  logic          am_own_q;
  logic          result_valid_q;
  logic          busy_q;

  // Next-state and datapath decisions for the sweep sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pwr_d        = pwr_q;
    am_prev_d    = am_prev_q;
    tmo_d        = tmo_q;
    best_index_d = best_index_q;
    best_power_d = best_power_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          tmo_d   = 1'b0;
          state_d = S_STEER;
        end
      end

      S_STEER: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end

      // pwr_valid is deliberately ignored while the beam settles.
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_PWR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A power word arriving on the final timeout cycle still wins.
      S_WAIT_PWR: begin
        if (pwr_valid) begin
          pwr_d   = pwr_data;
          state_d = S_WRITE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          pwr_d   = '0;
          tmo_d   = 1'b1;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_AM_START;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_STEER;
        end
      end

      // Pretend valid was already high so a level left over from the previous
      // argmax run cannot be mistaken for a fresh result.
      S_AM_START: begin
        am_prev_d = 1'b1;
        state_d   = S_AM_WAIT;
      end

      // Capture the result on the rising edge so best_* are already valid
      // during the DONE cycle, alongside the result_valid pulse.
      S_AM_WAIT: begin
        am_prev_d = am_valid;
        if (am_valid && !am_prev_q) begin
          best_index_d = am_max_index;
          best_power_d = am_max;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        if (continuous) begin
          idx_d   = '0;
          state_d = S_STEER;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, regardless of statement order.
    if (!reset_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      pwr_q          <= '0;
      am_prev_q      <= 1'b0;
      tmo_q          <= 1'b0;
      best_index_q   <= '0;
      best_power_q   <= '0;
      steer_idx_q    <= '0;
      steer_load_q   <= 1'b0;
      wren_q         <= 1'b0;
      am_start_q     <= 1'b0;
      am_own_q       <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      pwr_q          <= pwr_d;
      am_prev_q      <= am_prev_d;
      tmo_q          <= tmo_d;
      best_index_q   <= best_index_d;
      best_power_q   <= best_power_d;
      steer_load_q   <= (state_d == S_STEER);
      wren_q         <= (state_d == S_WRITE);
      am_start_q     <= (state_d == S_AM_START);
      am_own_q       <= (state_d == S_AM_START) || (state_d == S_AM_WAIT);
      result_valid_q <= (state_d == S_DONE);
      busy_q         <= (state_d != S_IDLE);
      // steer_idx only moves on a load and holds otherwise.
      if (state_d == S_STEER) begin
        steer_idx_q <= idx_d;
      end
    end
  end

  // Port A: the argmax engine drives the address while it owns the port.
  // wren_q is only set in WRITE, so no write can occur during ownership.
  assign ram_addr     = am_own_q ? am_addr : idx_q;
  assign ram_wdata    = pwr_q;
  assign ram_wren     = wren_q;

  assign steer_idx    = steer_idx_q;
  assign steer_load   = steer_load_q;
  assign am_start     = am_start_q;
  assign best_index   = best_index_q;
  assign best_power   = best_power_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_q;

endmodule
